// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle CPU control unit: states, opcodes,
// ALU functions, mux selects, and the bundle of decoded control lines.
package multicycle_pkg;

  localparam int unsigned OpW = 6;
  localparam int unsigned StW = 3;

  localparam logic [StW-1:0] StIf    = 3'b000;
  localparam logic [StW-1:0] StId    = 3'b001;
  localparam logic [StW-1:0] StExeLs = 3'b010;
  localparam logic [StW-1:0] StMem   = 3'b011;
  localparam logic [StW-1:0] StWbLd  = 3'b100;
  localparam logic [StW-1:0] StExeBr = 3'b101;
  localparam logic [StW-1:0] StExeAl = 3'b110;
  localparam logic [StW-1:0] StWbAl  = 3'b111;

  localparam logic [OpW-1:0] OpAdd   = 6'b000000;
  localparam logic [OpW-1:0] OpSub   = 6'b000001;
  localparam logic [OpW-1:0] OpAddi  = 6'b000010;
  localparam logic [OpW-1:0] OpOr    = 6'b010000;
  localparam logic [OpW-1:0] OpAnd   = 6'b010001;
  localparam logic [OpW-1:0] OpOri   = 6'b010010;
  localparam logic [OpW-1:0] OpSll   = 6'b011000;
  localparam logic [OpW-1:0] OpSlt   = 6'b100110;
  localparam logic [OpW-1:0] OpSltiu = 6'b100111;
  localparam logic [OpW-1:0] OpSw    = 6'b110000;
  localparam logic [OpW-1:0] OpLw    = 6'b110001;
  localparam logic [OpW-1:0] OpBeq   = 6'b110100;
  localparam logic [OpW-1:0] OpBne   = 6'b110101;
  localparam logic [OpW-1:0] OpBltz  = 6'b110110;
  localparam logic [OpW-1:0] OpJ     = 6'b111000;
  localparam logic [OpW-1:0] OpJr    = 6'b111001;
  localparam logic [OpW-1:0] OpJal   = 6'b111010;
  localparam logic [OpW-1:0] OpHalt  = 6'b111111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluSll = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluAnd = 3'b100;
  localparam logic [2:0] AluLtu = 3'b101;
  localparam logic [2:0] AluLt  = 3'b110;

  localparam logic [1:0] RegDst31 = 2'b00;
  localparam logic [1:0] RegDstRt = 2'b01;
  localparam logic [1:0] RegDstRd = 2'b10;

  localparam logic [1:0] PcSrcNext   = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcReg    = 2'b10;
  localparam logic [1:0] PcSrcJump   = 2'b11;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsLs,
    ClsBr,
    ClsJmp,
    ClsHalt,
    ClsNop
  } op_class_e;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       reg_wre;
    logic [1:0] reg_dst;
    logic       wr_reg_d_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ext_sel;
    logic [2:0] alu_op;
    logic       db_data_src;
    logic       m_rd;
    logic       m_wr;
    logic [1:0] pc_src;
  } ctrl_t;

  // Unknown opcodes fall into ClsNop and retire from ID like a jump to PC+4.
  function automatic op_class_e op_class(input logic [OpW-1:0] op);
    op_class_e cls;
    case (op)
      OpAdd, OpSub, OpAddi, OpOr, OpAnd, OpOri, OpSll, OpSlt, OpSltiu: cls = ClsAlu;
      OpSw, OpLw:                                                   cls = ClsLs;
      OpBeq, OpBne, OpBltz:                                         cls = ClsBr;
      OpJ, OpJr, OpJal:                                             cls = ClsJmp;
      OpHalt:                                                       cls = ClsHalt;
      default:                                                      cls = ClsNop;
    endcase
    return cls;
  endfunction

  function automatic logic is_rtype(input logic [OpW-1:0] op);
    return (op == OpAdd) || (op == OpSub) || (op == OpOr) || (op == OpAnd) ||
           (op == OpSll) || (op == OpSlt);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational decode of state, opcode and ALU flags into every datapath
// enable and mux select of the multicycle CPU.
module control_decode
  import multicycle_pkg::*;
(
  input  logic [StW-1:0] state,
  input  logic [OpW-1:0] opcode,
  input  logic           zero,
  input  logic           sign,
  output ctrl_t          ctrl
);

  op_class_e cls;
  logic      br_taken;

  assign cls = op_class(opcode);
  assign br_taken = ((opcode == OpBeq) && zero) || ((opcode == OpBne) && !zero) ||
                    ((opcode == OpBltz) && sign);

  always_comb begin
    ctrl = '0;

    // The opcode is stale during IF, so opcode-derived selects stay low there.
    if (state != StIf) begin
      ctrl.ext_sel      = (opcode != OpOri);
      ctrl.wr_reg_d_src = (opcode != OpJal);
      ctrl.db_data_src  = (opcode == OpLw);
      case (opcode)
        OpSub, OpBeq, OpBne, OpBltz: ctrl.alu_op = AluSub;
        OpSll: begin
          ctrl.alu_op    = AluSll;
          ctrl.alu_src_a = 1'b1;
        end
        OpOr, OpOri:                 ctrl.alu_op = AluOr;
        OpAnd:                       ctrl.alu_op = AluAnd;
        OpSltiu:                     ctrl.alu_op = AluLtu;
        OpSlt:                       ctrl.alu_op = AluLt;
        default:                     ctrl.alu_op = AluAdd;
      endcase
      ctrl.alu_src_b = (opcode == OpAddi) || (opcode == OpOri) || (opcode == OpSltiu) ||
                       (opcode == OpLw) || (opcode == OpSw);
    end

    case (state)
      StIf: ctrl.ir_wre = 1'b1;
      StId: begin
        if ((cls == ClsJmp) || (cls == ClsNop)) begin
          ctrl.pc_wre = 1'b1;
        end
        if ((opcode == OpJ) || (opcode == OpJal)) begin
          ctrl.pc_src = PcSrcJump;
        end else if (opcode == OpJr) begin
          ctrl.pc_src = PcSrcReg;
        end
        if (opcode == OpJal) begin
          ctrl.reg_wre = 1'b1;
          ctrl.reg_dst = RegDst31;
        end
      end
      StExeBr: begin
        ctrl.pc_wre = 1'b1;
        ctrl.pc_src = br_taken ? PcSrcBranch : PcSrcNext;
      end
      StMem: begin
        ctrl.m_rd   = (opcode == OpLw);
        ctrl.m_wr   = (opcode == OpSw);
        ctrl.pc_wre = (opcode == OpSw);
      end
      StWbLd: begin
        ctrl.pc_wre  = 1'b1;
        ctrl.reg_wre = 1'b1;
        ctrl.reg_dst = RegDstRt;
      end
      StWbAl: begin
        ctrl.pc_wre  = 1'b1;
        ctrl.reg_wre = 1'b1;
        ctrl.reg_dst = is_rtype(opcode) ? RegDstRd : RegDstRt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control unit for the multicycle CPU: state register, next-state logic
// and the optional retired-instruction counter (enabled by INST_COUNT_EN).
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned OPW = 6,
  parameter int unsigned STW = 3
) (
  input  logic           CLK,
  input  logic           CLR,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           sign,
  output logic [STW-1:0] state,
  output logic           PCWre,
  output logic           IRWre,
  output logic           RegWre,
  output logic [1:0]     RegDst,
  output logic           WrRegDSrc,
  output logic           ALUSrcA,
  output logic           ALUSrcB,
  output logic           ExtSel,
  output logic [2:0]     ALUOp,
  output logic           DBDataSrc,
  output logic           mRD,
  output logic           mWR,
  output logic [1:0]     PCSrc,
  output logic [31:0]    inst_count
);

  logic [STW-1:0] state_q, state_d;
  op_class_e      cls;
  ctrl_t          dec, ctrl;

  assign cls = op_class(opcode);

  always_comb begin
    state_d = StIf;
    case (state_q)
      StIf: state_d = StId;
      StId: begin
        case (cls)
          ClsAlu:  state_d = StExeAl;
          ClsLs:   state_d = StExeLs;
          ClsBr:   state_d = StExeBr;
          default: state_d = StIf;
        endcase
      end
      StExeLs: state_d = StMem;
      StMem:   state_d = (opcode == OpLw) ? StWbLd : StIf;
      StExeAl: state_d = StWbAl;
      default: state_d = StIf;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= StIf;
    end else begin
      state_q <= state_d;
    end
  end

  control_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .zero   (zero),
    .sign   (sign),
    .ctrl   (dec)
  );

  // Gate combinationally so enables drop the instant CLR falls.
  always_comb begin
    ctrl = dec;
    if (!CLR) begin
      ctrl = '0;
    end
  end

  assign state     = state_q;
  assign PCWre     = ctrl.pc_wre;
  assign IRWre     = ctrl.ir_wre;
  assign RegWre    = ctrl.reg_wre;
  assign RegDst    = ctrl.reg_dst;
  assign WrRegDSrc = ctrl.wr_reg_d_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ExtSel    = ctrl.ext_sel;
  assign ALUOp     = ctrl.alu_op;
  assign DBDataSrc = ctrl.db_data_src;
  assign mRD       = ctrl.m_rd;
  assign mWR       = ctrl.m_wr;
  assign PCSrc     = ctrl.pc_src;

`ifdef INST_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cnt_q <= '0;
    end else if (ctrl.pc_wre) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign inst_count = cnt_q;
`else
  assign inst_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and compares every control output against hand values.
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic [5:0]  opcode = 6'b000000;
  logic        zero = 1'b0;
  logic        sign = 1'b0;
  logic [2:0]  state;
  logic        PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel;
  logic        DBDataSrc, mRD, mWR;
  logic [1:0]  RegDst, PCSrc;
  logic [2:0]  ALUOp;
  logic [31:0] inst_count;

  int          total = 0;
  int          bad = 0;
  int          pcw_cnt = 0;
  logic [31:0] cnt_exp = 32'd0;
  logic [19:0] obs;

  always #5 CLK = ~CLK;

  multicycle_control dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .opcode     (opcode),
    .zero       (zero),
    .sign       (sign),
    .state      (state),
    .PCWre      (PCWre),
    .IRWre      (IRWre),
    .RegWre     (RegWre),
    .RegDst     (RegDst),
    .WrRegDSrc  (WrRegDSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ExtSel     (ExtSel),
    .ALUOp      (ALUOp),
    .DBDataSrc  (DBDataSrc),
    .mRD        (mRD),
    .mWR        (mWR),
    .PCSrc      (PCSrc),
    .inst_count (inst_count)
  );

  assign obs = {state, PCWre, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel,
                ALUOp, DBDataSrc, mRD, mWR, PCSrc};

  // Packs expected fields in the same order as obs; bit 16 is PCWre.
  function automatic logic [19:0] v(input logic [2:0] st, input logic pcw, input logic irw,
                                    input logic rw, input logic [1:0] rd, input logic wrs,
                                    input logic asa, input logic asb, input logic ext,
                                    input logic [2:0] aop, input logic dbs, input logic mrd,
                                    input logic mwr, input logic [1:0] pcs);
    return {st, pcw, irw, rw, rd, wrs, asa, asb, ext, aop, dbs, mrd, mwr, pcs};
  endfunction

  task automatic step(input logic pcw);
    @(posedge CLK);
    if (pcw) pcw_cnt++;
`ifdef INST_COUNT_EN
    cnt_exp = 32'(pcw_cnt);
`else
    cnt_exp = 32'd0;
`endif
    @(negedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (obs !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs obs=%h exp=%h", obs, 20'h0);
    end
    @(posedge CLK);
    #1;
    total++;
    if (obs !== 20'h0 || inst_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_hold obs=%h cnt=%0d exp=%h cnt=0", obs, inst_count, 20'h0);
    end
    @(negedge CLK);
    #1;
    CLR = 1'b1;
    #1;
  endtask

  task automatic test_add();
    logic [19:0] e [5];
    opcode = 6'b000000;
    e[0] = v(3'd0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0);
    e[1] = v(3'd1, 0, 0, 0, 2'd0, 1, 0, 0, 1, 3'd0, 0, 0, 0, 2'd0);
    e[2] = v(3'd6, 0, 0, 0, 2'd0, 1, 0, 0, 1, 3'd0, 0, 0, 0, 2'd0);
    e[3] = v(3'd7, 1, 0, 1, 2'd2, 1, 0, 0, 1, 3'd0, 0, 0, 0, 2'd0);
    e[4] = e[0];
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL add[%0d] obs=%h exp=%h", i, obs, e[i]);
      end
      if (i < 4) step(e[i][16]);
    end
    total++;
    if (inst_count !== cnt_exp) begin
      bad++;
      $display("FAIL add_count got=%0d exp=%0d", inst_count, cnt_exp);
    end
  endtask

  task automatic test_lw();
    logic [19:0] e [6];
    opcode = 6'b110001;
    e[0] = v(3'd0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0);
    e[1] = v(3'd1, 0, 0, 0, 2'd0, 1, 0, 1, 1, 3'd0, 1, 0, 0, 2'd0);
    e[2] = v(3'd2, 0, 0, 0, 2'd0, 1, 0, 1, 1, 3'd0, 1, 0, 0, 2'd0);
    e[3] = v(3'd3, 0, 0, 0, 2'd0, 1, 0, 1, 1, 3'd0, 1, 1, 0, 2'd0);
    e[4] = v(3'd4, 1, 0, 1, 2'd1, 1, 0, 1, 1, 3'd0, 1, 0, 0, 2'd0);
    e[5] = e[0];
    for (int i = 0; i < 6; i++) begin
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL lw[%0d] obs=%h exp=%h", i, obs, e[i]);
      end
      if (i < 5) step(e[i][16]);
    end
    total++;
    if (inst_count !== cnt_exp) begin
      bad++;
      $display("FAIL lw_count got=%0d exp=%0d", inst_count, cnt_exp);
    end
  endtask

  task automatic test_branch();
    logic [5:0]  ops [3] = '{6'b110100, 6'b110100, 6'b110110};
    logic        zs [3]  = '{1'b1, 1'b0, 1'b0};
    logic        ss [3]  = '{1'b0, 1'b0, 1'b1};
    logic [1:0]  pcs [3] = '{2'd1, 2'd0, 2'd1};
    logic [19:0] e [4];
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      zero = zs[k];
      sign = ss[k];
      e[0] = v(3'd0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0);
      e[1] = v(3'd1, 0, 0, 0, 2'd0, 1, 0, 0, 1, 3'd1, 0, 0, 0, 2'd0);
      e[2] = v(3'd5, 1, 0, 0, 2'd0, 1, 0, 0, 1, 3'd1, 0, 0, 0, pcs[k]);
      e[3] = e[0];
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs !== e[i]) begin
          bad++;
          $display("FAIL branch%0d[%0d] obs=%h exp=%h", k, i, obs, e[i]);
        end
        if (i < 3) step(e[i][16]);
      end
    end
    zero = 1'b0;
    sign = 1'b0;
  endtask

  task automatic test_jal_nop();
    logic [5:0]  ops [2] = '{6'b111010, 6'b111110};
    logic [19:0] e [2][3];
    e[0][0] = v(3'd0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0);
    e[0][1] = v(3'd1, 1, 0, 1, 2'd0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 2'd3);
    e[0][2] = e[0][0];
    e[1][0] = e[0][0];
    e[1][1] = v(3'd1, 1, 0, 0, 2'd0, 1, 0, 0, 1, 3'd0, 0, 0, 0, 2'd0);
    e[1][2] = e[0][0];
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k];
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs !== e[k][i]) begin
          bad++;
          $display("FAIL jump%0d[%0d] obs=%h exp=%h", k, i, obs, e[k][i]);
        end
        if (i < 2) step(e[k][i][16]);
      end
    end
    total++;
    if (inst_count !== cnt_exp) begin
      bad++;
      $display("FAIL jump_count got=%0d exp=%0d", inst_count, cnt_exp);
    end
  endtask

  task automatic test_halt();
    logic [19:0] e_if, e_id;
    int          hits = 0;
    opcode = 6'b111111;
    e_if = v(3'd0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0);
    e_id = v(3'd1, 0, 0, 0, 2'd0, 1, 0, 0, 1, 3'd0, 0, 0, 0, 2'd0);
    for (int i = 0; i < 20; i++) begin
      if (obs !== ((i % 2 == 0) ? e_if : e_id)) hits++;
      step(1'b0);
    end
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL halt_loop bad_cycles=%0d required=0", hits);
    end
    total++;
    if (inst_count !== cnt_exp) begin
      bad++;
      $display("FAIL halt_count got=%0d exp=%0d", inst_count, cnt_exp);
    end
  endtask

  task automatic test_async_clr();
    logic [19:0] e [4];
    opcode = 6'b110000;
    e[0] = v(3'd0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0);
    e[1] = v(3'd1, 0, 0, 0, 2'd0, 1, 0, 1, 1, 3'd0, 0, 0, 0, 2'd0);
    e[2] = v(3'd2, 0, 0, 0, 2'd0, 1, 0, 1, 1, 3'd0, 0, 0, 0, 2'd0);
    e[3] = v(3'd3, 1, 0, 0, 2'd0, 1, 0, 1, 1, 3'd0, 0, 0, 1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs !== e[i]) begin
        bad++;
        $display("FAIL sw[%0d] obs=%h exp=%h", i, obs, e[i]);
      end
      if (i < 3) step(e[i][16]);
    end
    #1;
    CLR = 1'b0;
    #1;
    total++;
    if (mWR !== 1'b0 || obs !== 20'h0) begin
      bad++;
      $display("FAIL clr_async mWR=%b obs=%h exp mWR=0 obs=%h", mWR, obs, 20'h0);
    end
    pcw_cnt = 0;
    cnt_exp = 32'd0;
    @(negedge CLK);
    #1;
    total++;
    if (inst_count !== 32'd0) begin
      bad++;
      $display("FAIL clr_count got=%0d exp=0", inst_count);
    end
    CLR = 1'b1;
    #1;
    total++;
    if (obs !== e[0]) begin
      bad++;
      $display("FAIL clr_release_if obs=%h exp=%h", obs, e[0]);
    end
    step(1'b0);
    total++;
    if (obs !== e[1]) begin
      bad++;
      $display("FAIL clr_release_id obs=%h exp=%h", obs, e[1]);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_jal_nop();
    test_halt();
    test_async_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
